shift_register8: RTL and testbench



---
 rtl/shift_register8.sv | 96 +++++++++
 tb/tb_shift_register8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_register8.sv
// SPI byte shifter: hold, parallel load, or shift left/right by one bit on each enabled clk.
// Define SHIFTREG_BITCOUNT_EN to add the bitCount/frameDone outputs.
`ifndef HOLD
`define HOLD  2'd0
`endif
`ifndef LEFT
`define LEFT  2'd1
`endif
`ifndef RIGHT
`define RIGHT 2'd2
`endif
`ifndef PLOAD
`define PLOAD 2'd3
`endif

module shift_register8 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serialClkposedge,
    input  logic [1:0]       mode,
    input  logic [width-1:0] parallelIn,
    input  logic             serialIn,
    output logic [width-1:0] parallelOut,
    output logic             serialOut
`ifdef SHIFTREG_BITCOUNT_EN
    ,
    output logic [$clog2(width):0] bitCount,
    output logic                   frameDone
`endif
);

    logic [width-1:0] shreg_d, shreg_q;

    always_comb begin
        shreg_d = shreg_q;
        if (serialClkposedge) begin
            case (mode)
                `LEFT:   shreg_d = {shreg_q[width-2:0], serialIn};
                `RIGHT:  shreg_d = {serialIn, shreg_q[width-1:1]};
                `PLOAD:  shreg_d = parallelIn;
                default: shreg_d = shreg_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shreg_q <= '0;
        else        shreg_q <= shreg_d;
    end

    assign parallelOut = shreg_q;
    // The outgoing bit is the one a shift in the current mode would discard.
    assign serialOut   = (mode == `RIGHT) ? shreg_q[0] : shreg_q[width-1];

`ifdef SHIFTREG_BITCOUNT_EN
    localparam int            CW   = $clog2(width) + 1;
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          done_d, done_q;

    // The count wraps on the shift that completes a frame, so it never holds width itself.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (serialClkposedge) begin
            if (mode == `PLOAD) begin
                cnt_d = '0;
            end else if (mode == `LEFT || mode == `RIGHT) begin
                if (cnt_q == LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bitCount  = cnt_q;
    assign frameDone = done_q;
`endif

endmodule

// File: tb/tb_shift_register8.sv
// Directed-vector bench for shift_register8: driver queues expected results, monitor checks them.
`timescale 1ns/1ps
module tb_shift_register8;

    localparam logic [1:0] M_HOLD = 2'd0, M_LEFT = 2'd1, M_RIGHT = 2'd2, M_PLOAD = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serialClkposedge = 1'b0;
    logic [1:0] mode = M_HOLD;
    logic [7:0] parallelIn = 8'h00;
    logic       serialIn = 1'b0;
    logic [7:0] parallelOut;
    logic       serialOut;
`ifdef SHIFTREG_BITCOUNT_EN
    logic [3:0] bitCount;
    logic       frameDone;
`endif

    shift_register8 #(.width(8)) dut (
        .clk(clk), .rst_n(rst_n), .serialClkposedge(serialClkposedge), .mode(mode),
        .parallelIn(parallelIn), .serialIn(serialIn),
        .parallelOut(parallelOut), .serialOut(serialOut)
`ifdef SHIFTREG_BITCOUNT_EN
        , .bitCount(bitCount), .frameDone(frameDone)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      name;
        logic [7:0] po;
        logic       so;
        logic       cb;
        logic [3:0] bc;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: one cycle after each issued operation the result is due; sample #1 after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) begin
                    check({e.name, "_late"}, 32'(e.due), 32'(cyc));
                end else begin
                    check({e.name, "_po"}, 32'(parallelOut), 32'(e.po));
                    check({e.name, "_so"}, 32'(serialOut), 32'(e.so));
`ifdef SHIFTREG_BITCOUNT_EN
                    if (e.cb) begin
                        check({e.name, "_bc"}, 32'(bitCount), 32'(e.bc));
                        check({e.name, "_fd"}, 32'(frameDone), 32'(e.fd));
                    end
`endif
                end
            end
        end
    end

    task automatic op(input logic [1:0] m, input logic s, input logic [7:0] pi, input logic si,
                      input string nm, input logic [7:0] po, input logic so,
                      input logic cb = 1'b0, input logic [3:0] bc = 4'd0, input logic fd = 1'b0);
        exp_t e;
        @(posedge clk);
        #2;
        mode = m; serialClkposedge = s; parallelIn = pi; serialIn = si;
        e.due = cyc + 1; e.name = nm; e.po = po; e.so = so; e.cb = cb; e.bc = bc; e.fd = fd;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        serialClkposedge = 1'b0;
    endtask

    logic [7:0] left_po [5] = '{8'h08, 8'h11, 8'h23, 8'h47, 8'h8F};
    logic       left_si [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       left_so [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] right_po[8] = '{8'h80, 8'h40, 8'hA0, 8'h50, 8'hA8, 8'h54, 8'h2A, 8'h15};
    logic       right_si[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       right_so[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef SHIFTREG_BITCOUNT_EN
    logic [7:0] bc_po[8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
`endif

    initial begin : driver
        #3;
        check("reset_po", 32'(parallelOut), 32'h00);
        check("reset_so", 32'(serialOut), 32'h0);
`ifdef SHIFTREG_BITCOUNT_EN
        check("reset_bc", 32'(bitCount), 32'h0);
        check("reset_fd", 32'(frameDone), 32'h0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Load, one shift, then an asynchronous reset in the middle of a shifting phase.
        op(M_PLOAD, 1'b1, 8'h77, 1'b0, "pload_77", 8'h77, 1'b0);
        op(M_LEFT,  1'b1, 8'h00, 1'b1, "left_pre", 8'hEF, 1'b1);
        idle();
        serialClkposedge = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_po", 32'(parallelOut), 32'h00);
        check("async_reset_so", 32'(serialOut), 32'h0);
        @(posedge clk);
        #1;
        check("reset_dominates_po", 32'(parallelOut), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        serialClkposedge = 1'b0;

        // Hold ignores data; load with strobe low does nothing.
        op(M_PLOAD, 1'b1, 8'h7F, 1'b0, "hold_load", 8'h7F, 1'b0);
        for (int i = 0; i < 4; i++)
            op(M_HOLD, 1'b1, (i % 2 == 0) ? 8'h78 : 8'h2C, 1'b1, $sformatf("hold_%0d", i), 8'h7F, 1'b0);
        op(M_PLOAD, 1'b0, 8'h78, 1'b1, "pload_nostrobe", 8'h7F, 1'b0);

        // serialOut follows the mode: MSB before the first left shift, LSB for right.
        op(M_PLOAD, 1'b1, 8'h80, 1'b0, "load_80", 8'h80, 1'b1);
        op(M_LEFT,  1'b0, 8'h00, 1'b0, "left_msb_first", 8'h80, 1'b1);
        op(M_RIGHT, 1'b0, 8'h00, 1'b0, "right_lsb", 8'h80, 1'b0);

        op(M_PLOAD, 1'b1, 8'h04, 1'b0, "left_load", 8'h04, 1'b0);
        for (int i = 0; i < 5; i++)
            op(M_LEFT, 1'b1, 8'hFF, left_si[i], $sformatf("left_%0d", i), left_po[i], left_so[i]);

        op(M_PLOAD, 1'b1, 8'h00, 1'b1, "right_load", 8'h00, 1'b0);
        for (int i = 0; i < 8; i++)
            op(M_RIGHT, 1'b1, 8'hFF, right_si[i], $sformatf("right_%0d", i), right_po[i], right_so[i]);

        // Strobe gating: no change while low, exactly one shift for one strobe.
        for (int i = 0; i < 5; i++)
            op(M_LEFT, 1'b0, 8'h00, 1'b1, $sformatf("gate_idle_%0d", i), 8'h15, 1'b0);
        op(M_LEFT, 1'b1, 8'h00, 1'b1, "gate_shift", 8'h2B, 1'b0);
        op(M_LEFT, 1'b0, 8'h00, 1'b1, "gate_after", 8'h2B, 1'b0);

`ifdef SHIFTREG_BITCOUNT_EN
        op(M_PLOAD, 1'b1, 8'h00, 1'b0, "bc_load", 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            op(M_LEFT, 1'b1, 8'h00, 1'b1, $sformatf("bc_left_%0d", i), bc_po[i], 1'b0,
               1'b1, 4'(i + 1), 1'b0);
        op(M_LEFT, 1'b1, 8'h00, 1'b1, "bc_frame", 8'hFF, 1'b1, 1'b1, 4'd0, 1'b1);
        op(M_HOLD, 1'b1, 8'h00, 1'b0, "bc_hold", 8'hFF, 1'b1, 1'b1, 4'd0, 1'b0);
        op(M_RIGHT, 1'b1, 8'h00, 1'b0, "bc_r1", 8'h7F, 1'b1, 1'b1, 4'd1, 1'b0);
        op(M_RIGHT, 1'b1, 8'h00, 1'b0, "bc_r2", 8'h3F, 1'b1, 1'b1, 4'd2, 1'b0);
        op(M_RIGHT, 1'b1, 8'h00, 1'b0, "bc_r3", 8'h1F, 1'b1, 1'b1, 4'd3, 1'b0);
        op(M_RIGHT, 1'b0, 8'h00, 1'b0, "bc_nostrobe", 8'h1F, 1'b1, 1'b1, 4'd3, 1'b0);
        op(M_PLOAD, 1'b1, 8'h5A, 1'b0, "bc_reload", 8'h5A, 1'b0, 1'b1, 4'd0, 1'b0);
`endif

        idle();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
